// File: rtl/disp_scan_ctrl_pkg.sv
// Shared types and helpers for the multiplexed 4-digit 7-segment scan controller.
package disp_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [3:0] bcd_t;
    typedef bcd_t [NUM_DIGITS-1:0] bcd_word_t;

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} scan_state_t;

    // True when digit idx is a leading zero: not the units digit, and it plus every higher digit is 0.
    function automatic logic lz_dark(input bcd_word_t w, input logic [1:0] idx);
        logic dark;
        dark = (idx != 2'd0);
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j >= int'(idx) && w[j] != 4'd0) begin
                dark = 1'b0;
            end
        end
        return dark;
    endfunction

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Control/display bundle between the value producer, the scan controller and the segment decoder.
interface disp_scan_ctrl_if;
    import disp_pkg::*;

    logic      en_i;
    logic      load_i;
    bcd_word_t digits_i;
    bcd_t      digit_o;
    logic [3:0] anodes_o;
    logic      pending_o;
    logic      frame_done_o;

    modport master (
        output en_i, load_i, digits_i,
        input  digit_o, anodes_o, pending_o, frame_done_o
    );

    modport slave (
        input  en_i, load_i, digits_i,
        output digit_o, anodes_o, pending_o, frame_done_o
    );

endinterface

// File: rtl/disp_scan_ctrl_phase_counter.sv
// Phase counter: counts 0..i_tc while enabled and pulses o_wrap on the terminal cycle.
module disp_phase_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_tc,
    output logic             o_wrap
);

    logic [WIDTH-1:0] r_cnt;

    assign o_wrap = i_en && !i_clr && (r_cnt == i_tc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || o_wrap) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Digit-scan frame scheduler with tear-free shadow commit and per-slot blanking.
// Define DISP_LZ_BLANK_EN to keep leading-zero digits dark.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV = 27000,
    parameter int BLANK_CYC   = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    disp_scan_ctrl_if.slave  bus
);

    localparam int SHOW_CYC = REFRESH_DIV - BLANK_CYC;
    localparam int CNT_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] BLANK_TC = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SHOW_TC  = CNT_W'(SHOW_CYC - 1);
    localparam logic [1:0] LAST_IDX = 2'(NUM_DIGITS - 1);

    scan_state_t r_state, w_state_next;
    logic [1:0]  r_idx, w_idx_next;
    bcd_word_t   r_shadow, w_shadow_next;
    bcd_word_t   r_active, w_active_next;
    logic        r_pending, w_pending_next;
    bcd_t        r_digit, w_digit_next;
    logic [3:0]  r_anodes, w_anodes_next;
    logic        r_frame_done, w_frame_done_next;

    logic             w_wrap;
    logic             w_commit;
    logic             w_lit;
    logic             w_cnt_clr;
    logic             w_cnt_en;
    logic [CNT_W-1:0] w_tc;

    // One counter serves both phases; its terminal count follows the current state.
    assign w_cnt_clr = (r_state == IDLE) || !bus.en_i;
    assign w_cnt_en  = (r_state != IDLE);
    assign w_tc      = (r_state == BLANK) ? BLANK_TC : SHOW_TC;

    disp_phase_counter #(.WIDTH(CNT_W)) u_phase (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_cnt_clr),
        .i_en   (w_cnt_en),
        .i_tc   (w_tc),
        .o_wrap (w_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_idx        <= LAST_IDX;
            r_shadow     <= '0;
            r_active     <= '0;
            r_pending    <= 1'b0;
            r_digit      <= '0;
            r_anodes     <= 4'b1111;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_idx        <= w_idx_next;
            r_shadow     <= w_shadow_next;
            r_active     <= w_active_next;
            r_pending    <= w_pending_next;
            r_digit      <= w_digit_next;
            r_anodes     <= w_anodes_next;
            r_frame_done <= w_frame_done_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_idx_next        = r_idx;
        w_digit_next      = r_digit;
        w_frame_done_next = 1'b0;
        w_commit          = 1'b0;

        if (!bus.en_i) begin
            w_state_next = IDLE;
            w_idx_next   = LAST_IDX;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_next = BLANK;
                    w_idx_next   = LAST_IDX;
                end
                BLANK: begin
                    if (w_wrap) w_state_next = SHOW;
                end
                SHOW: begin
                    if (w_wrap) begin
                        w_state_next = BLANK;
                        w_idx_next   = r_idx - 2'd1;
                        if (r_idx == 2'd0) begin
                            w_frame_done_next = 1'b1;
                            w_commit          = r_pending;
                        end
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end

        // Old shadow commits before a same-edge load overwrites it.
        w_active_next  = w_commit ? r_shadow : r_active;
        w_shadow_next  = bus.load_i ? bus.digits_i : r_shadow;
        w_pending_next = bus.load_i ? 1'b1 : (w_commit ? 1'b0 : r_pending);

        if (w_state_next == BLANK && r_state != BLANK) begin
            w_digit_next = w_active_next[w_idx_next];
        end

        w_lit = 1'b1;
`ifdef DISP_LZ_BLANK_EN
        w_lit = !lz_dark(r_active, w_idx_next);
`endif
        w_anodes_next = 4'b1111;
        if (w_state_next == SHOW && w_lit) begin
            w_anodes_next = ~(4'b0001 << w_idx_next);
        end
    end

    assign bus.digit_o      = r_digit;
    assign bus.anodes_o     = r_anodes;
    assign bus.pending_o    = r_pending;
    assign bus.frame_done_o = r_frame_done;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed self-checking bench for disp_scan_ctrl with REFRESH_DIV = 8, BLANK_CYC = 2.
module tb_disp_scan_ctrl;

    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FRAME = 4 * RD;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    disp_scan_ctrl_if bus ();

    disp_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected anodes at cycle i of a frame (i = 0 is the first BLANK cycle of digit 3).
    function automatic logic [3:0] exp_anodes(input logic [15:0] val, input int i);
        int ph;
        int idx;
        logic [3:0] one;
        one = 4'b0001;
        ph  = i % RD;
        idx = 3 - i / RD;
        if (ph < BC) return 4'b1111;
`ifdef DISP_LZ_BLANK_EN
        if (idx != 0) begin
            logic zero;
            zero = 1'b1;
            for (int j = idx; j < 4; j++) begin
                if (val[j*4 +: 4] != 4'd0) zero = 1'b0;
            end
            if (zero) return 4'b1111;
        end
`endif
        return ~(one << idx);
    endfunction

    // Runs one frame from its first BLANK cycle, checking every cycle; optional loads at la/lb.
    task automatic run_frame(input logic [15:0] val, input logic fd_first,
                             input logic pend0, input logic pend31,
                             input int la, input logic [15:0] va,
                             input int lb, input logic [15:0] vb);
        int idx;
        for (int i = 0; i < FRAME; i++) begin
            idx = 3 - i / RD;
            check($sformatf("anodes[%0d]", i), 32'(bus.anodes_o), 32'(exp_anodes(val, i)));
            check($sformatf("digit[%0d]", i), 32'(bus.digit_o), 32'(val[idx*4 +: 4]));
            check($sformatf("fdone[%0d]", i), 32'(bus.frame_done_o), 32'((i == 0) && fd_first));
            if (i == 0)  check("pend_start", 32'(bus.pending_o), 32'(pend0));
            if (i == 31) check("pend_end", 32'(bus.pending_o), 32'(pend31));
            if (i == la) begin
                bus.load_i = 1'b1; bus.digits_i = va;
            end else if (i == lb) begin
                bus.load_i = 1'b1; bus.digits_i = vb;
            end else begin
                bus.load_i = 1'b0;
            end
            @(negedge clk);
        end
        bus.load_i = 1'b0;
        $display("frame val=%04h fd_first=%0d checks=%0d errors=%0d", val, fd_first, n_checks, n_errors);
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst_n        = 1'b0;
        bus.en_i     = 1'b0;
        bus.load_i   = 1'b0;
        bus.digits_i = '0;

        @(negedge clk);
        check("rst_anodes", 32'(bus.anodes_o), 32'hF);
        check("rst_digit", 32'(bus.digit_o), 32'h0);
        check("rst_pending", 32'(bus.pending_o), 32'h0);
        check("rst_fdone", 32'(bus.frame_done_o), 32'h0);
        $display("reset checked: checks=%0d errors=%0d", n_checks, n_errors);

        // Enable together with a load of 1234: first frame still shows 0000.
        rst_n = 1'b1; bus.en_i = 1'b1; bus.load_i = 1'b1; bus.digits_i = 16'h1234;
        @(negedge clk);
        bus.load_i = 1'b0;
        run_frame(16'h0000, 1'b0, 1'b1, 1'b1, -1, 16'h0, -1, 16'h0);
        run_frame(16'h1234, 1'b1, 1'b0, 1'b0, -1, 16'h0, -1, 16'h0);
        // Tear-free: 5678 loaded in SHOW of idx 2 only appears next frame.
        run_frame(16'h1234, 1'b1, 1'b0, 1'b1, 10, 16'h5678, -1, 16'h0);
        // Collision: 4321 pending, 9999 loaded on the commit edge.
        run_frame(16'h5678, 1'b1, 1'b0, 1'b1, 5, 16'h4321, 31, 16'h9999);
        run_frame(16'h4321, 1'b1, 1'b1, 1'b1, -1, 16'h0, -1, 16'h0);
        run_frame(16'h9999, 1'b1, 1'b0, 1'b0, -1, 16'h0, -1, 16'h0);

        // Enable drop during SHOW of idx 1.
        for (int i = 0; i < 2 * RD + BC; i++) @(negedge clk);
        check("drop_pre_anodes", 32'(bus.anodes_o), 32'hD);
        bus.en_i = 1'b0;
        @(negedge clk);
        check("drop_anodes", 32'(bus.anodes_o), 32'hF);
        check("drop_digit", 32'(bus.digit_o), 32'h9);
        check("drop_fdone", 32'(bus.frame_done_o), 32'h0);
        repeat (3) @(negedge clk);
        check("idle_anodes", 32'(bus.anodes_o), 32'hF);
        $display("enable drop: checks=%0d errors=%0d", n_checks, n_errors);
        bus.en_i = 1'b1;
        @(negedge clk);
        run_frame(16'h9999, 1'b0, 1'b0, 1'b0, -1, 16'h0, -1, 16'h0);

        // Asynchronous reset in the middle of SHOW of idx 3.
        repeat (3) @(negedge clk);
        check("pre_rst_anodes", 32'(bus.anodes_o), 32'h7);
        #2 rst_n = 1'b0;
        #1;
        check("arst_anodes", 32'(bus.anodes_o), 32'hF);
        check("arst_digit", 32'(bus.digit_o), 32'h0);
        check("arst_fdone", 32'(bus.frame_done_o), 32'h0);
        check("arst_pending", 32'(bus.pending_o), 32'h0);
        bus.en_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_anodes", 32'(bus.anodes_o), 32'hF);
        check("post_rst_pending", 32'(bus.pending_o), 32'h0);
        $display("async reset: checks=%0d errors=%0d", n_checks, n_errors);

        // Restart from reset: 0000 frame, then 0070 (leading zeros dark when enabled).
        bus.en_i = 1'b1; bus.load_i = 1'b1; bus.digits_i = 16'h0070;
        @(negedge clk);
        bus.load_i = 1'b0;
        run_frame(16'h0000, 1'b0, 1'b1, 1'b1, -1, 16'h0, -1, 16'h0);
        run_frame(16'h0070, 1'b1, 1'b0, 1'b0, -1, 16'h0, -1, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
